// File: rtl/rll27_decoder.sv
// RLL(2,7) line decoder: NRZI line level -> channel bits -> prefix-free codeword
// parser -> small bit FIFO drained one bit per data_valid/data_ready handshake.
module rll27_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 code_in,
    input  logic                 code_valid,
    input  logic                 sync,
    output logic                 data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 code_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           word_len,
    output logic                 dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Line tracking and parser state
    logic       prev_lvl;
    logic [6:0] pbuf;
    logic [3:0] pcnt;

    logic       bit_en;
    logic       cb;
    logic [7:0] pbuf_nxt;
    logic [3:0] pcnt_nxt;
    logic       match;
    logic [3:0] dec_word;
    logic [2:0] dec_len;
    logic       word_hit;
    logic       word_err;

    // FIFO state
    logic          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] free_cnt;
    logic [CW-1:0] push_len;
    logic          push;
    logic          pop;

    assign dbg_state = (state == RUN);

    // FSM: the sync pulse is the only way out of HUNT; RUN is left only by reset.
    always_comb begin
        state_nxt = state;
        bit_en    = 1'b0;
        case (state)
            HUNT: begin
                if (sync) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bit_en = code_valid && !sync;
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // dec_word is left-justified: bit 3 is the first recovered data bit.
    always_comb begin
        cb       = code_in ^ prev_lvl;
        pbuf_nxt = {pbuf, cb};
        pcnt_nxt = pcnt + 4'd1;
        match    = 1'b0;
        dec_word = 4'b0000;
        dec_len  = 3'd0;
        case (pcnt_nxt)
            4'd4: begin
                if (pbuf_nxt[3:0] == 4'b0100) begin
                    match = 1'b1; dec_word = 4'b1000; dec_len = 3'd2;
                end else if (pbuf_nxt[3:0] == 4'b1000) begin
                    match = 1'b1; dec_word = 4'b1100; dec_len = 3'd2;
                end
            end
            4'd6: begin
                if (pbuf_nxt[5:0] == 6'b000100) begin
                    match = 1'b1; dec_word = 4'b0000; dec_len = 3'd3;
                end else if (pbuf_nxt[5:0] == 6'b100100) begin
                    match = 1'b1; dec_word = 4'b0100; dec_len = 3'd3;
                end else if (pbuf_nxt[5:0] == 6'b001000) begin
                    match = 1'b1; dec_word = 4'b0110; dec_len = 3'd3;
                end
            end
            4'd8: begin
                if (pbuf_nxt == 8'b00100100) begin
                    match = 1'b1; dec_word = 4'b0010; dec_len = 3'd4;
                end else if (pbuf_nxt == 8'b00001000) begin
                    match = 1'b1; dec_word = 4'b0011; dec_len = 3'd4;
                end
            end
            default: begin
                match = 1'b0;
            end
        endcase
        word_hit = bit_en && match;
        word_err = bit_en && !match && (pcnt_nxt == 4'd8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_lvl <= 1'b0;
            pbuf     <= '0;
            pcnt     <= '0;
            word_len <= '0;
            overflow <= 1'b0;
            code_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            code_err <= word_err;
            if (sync) begin
                prev_lvl <= code_in;
                pcnt     <= '0;
                word_len <= '0;
                overflow <= 1'b0;
            end else if (bit_en) begin
                prev_lvl <= code_in;
                pbuf     <= pbuf_nxt[6:0];
                if (match || (pcnt_nxt == 4'd8)) begin
                    pcnt <= '0;
                end else begin
                    pcnt <= pcnt_nxt;
                end
                if (match) begin
                    word_len <= dec_len;
                end
                if (word_hit && !push) begin
                    overflow <= 1'b1;
                end
            end
            if (word_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    // Output handshake: data_out is presented whenever data_valid is high and
    // is consumed on every rising edge where data_valid and data_ready are both
    // high; data_out/data_valid only change after such an edge or a push.
    assign data_valid = (fifo_cnt != '0);
    assign data_out   = data_valid ? mem[rd_ptr] : 1'b0;
    assign pop        = data_valid && data_ready;

    // Space is judged before this cycle's pop so a full FIFO never takes a word.
    assign free_cnt = CW'(FIFO_DEPTH) - fifo_cnt;
    assign push     = word_hit && (free_cnt >= CW'(dec_len));
    assign push_len = push ? CW'(dec_len) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            fifo_cnt <= fifo_cnt + push_len - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(dec_len);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < dec_len) begin
                    mem[wr_ptr + AW'(i)] <= dec_word[3 - i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rll27_decoder.sv
// Bench for rll27_decoder: directed and random line streams against a
// codeword-table reference model, with a queue-based data scoreboard.
module tb_rll27_decoder;

  localparam int FIFO_DEPTH = 8;
  localparam int ERR_CNT_W  = 8;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic code_in = 1'b0;
  logic code_valid = 1'b0;
  logic sync = 1'b0;
  logic data_ready = 1'b0;
  logic data_out;
  logic data_valid;
  logic code_err;
  logic overflow;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [2:0] word_len;
  logic dbg_state;

  int errors = 0;
  int checks = 0;

  rll27_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .sync(sync), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .code_err(code_err), .overflow(overflow),
    .err_cnt(err_cnt), .word_len(word_len), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // code table: code bits and data bits right-justified, first bit leftmost
  logic [7:0] tbl_code [7] = '{8'b0100, 8'b1000, 8'b000100, 8'b100100,
                               8'b001000, 8'b00100100, 8'b00001000};
  int         tbl_clen [7] = '{4, 4, 6, 6, 6, 8, 8};
  logic [3:0] tbl_data [7] = '{4'b10, 4'b11, 4'b000, 4'b010, 4'b011,
                               4'b0010, 4'b0011};
  int         tbl_dlen [7] = '{2, 2, 3, 3, 3, 4, 4};

  // reference model state (value after the most recent clock edge)
  bit   m_run;
  bit   m_prev;
  bit   cw_q[$];
  int   m_len;
  int   m_err;
  int   m_cnt;
  bit   m_ovf;
  int   m_occ;
  logic [0:0] exp_q[$];

  logic cur_lvl = 1'b0;
  logic rdy_tog = 1'b0;
  int   rdy_pct = 50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_prev = 0; cw_q.delete(); m_len = 0; m_err = 0;
    m_cnt = 0; m_ovf = 0; m_occ = 0; exp_q.delete();
  endtask

  // Advance the model over the clock edge that just passed, using the inputs
  // that were held across it.
  task automatic model_edge();
    bit pop;
    bit cb;
    int v;
    int hit;
    if (!rst_n) return;
    pop = (m_occ > 0) && data_ready;
    m_err = 0;
    if (sync) begin
      m_run = 1; m_prev = code_in; cw_q.delete(); m_len = 0; m_ovf = 0;
    end else if (m_run && code_valid) begin
      cb = code_in ^ m_prev;
      m_prev = code_in;
      cw_q.push_back(cb);
      v = 0;
      foreach (cw_q[i]) v = v * 2 + int'(cw_q[i]);
      hit = -1;
      for (int k = 0; k < 7; k++)
        if (tbl_clen[k] == cw_q.size() && int'(tbl_code[k]) == v) hit = k;
      if (hit >= 0) begin
        m_len = tbl_dlen[hit];
        cw_q.delete();
        if (FIFO_DEPTH - m_occ >= tbl_dlen[hit]) begin
          for (int j = tbl_dlen[hit] - 1; j >= 0; j--) exp_q.push_back(tbl_data[hit][j]);
          m_occ += tbl_dlen[hit];
        end else begin
          m_ovf = 1;
        end
      end else if (cw_q.size() == 8) begin
        m_err = 1;
        if (m_cnt < ERR_MAX) m_cnt++;
        cw_q.delete();
      end
    end
    if (pop) m_occ--;
  endtask

  // monitor / scoreboard: compare at the falling edge, between drive and edge
  initial begin
    forever begin
      @(negedge clk);
      chk("data_valid", data_valid, int'(m_occ != 0));
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_out: got unexpected bit %0d expected none at %0t", data_out, $time);
        end else begin
          chk("data_out", data_out, exp_q.pop_front());
        end
      end else if (!data_valid) begin
        chk("data_out_empty", data_out, 0);
      end
      chk("code_err", code_err, m_err);
      chk("err_cnt", err_cnt, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("word_len", word_len, m_len);
      chk("fsm_state", dbg_state, m_run);
    end
  end

  // driver tasks
  task automatic cycle(input logic cv, input logic lvl, input logic sy, input logic rdy);
    @(posedge clk); #2;
    model_edge();
    code_valid = cv; code_in = lvl; sync = sy; data_ready = rdy;
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    if (mode == 2) begin
      rdy_tog = ~rdy_tog;
      return rdy_tog;
    end
    return logic'($urandom_range(0, 99) < rdy_pct);
  endfunction

  // mode: 0 ready low, 1 ready high, 2 ready toggling, 3 random ready + gaps
  task automatic send_cb(input logic [7:0] bits, input int n, input int mode);
    for (int j = n - 1; j >= 0; j--) begin
      if (mode == 3 && $urandom_range(0, 3) == 0)
        cycle(1'b0, logic'($urandom_range(0, 1)), 1'b0, pick_rdy(mode));
      cur_lvl = cur_lvl ^ bits[j];
      cycle(1'b1, cur_lvl, 1'b0, pick_rdy(mode));
    end
  endtask

  task automatic do_sync(input logic lvl, input int mode);
    cur_lvl = lvl;
    cycle(1'b1, lvl, 1'b1, pick_rdy(mode));
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) cycle(1'b0, cur_lvl, 1'b0, pick_rdy(mode));
  endtask

  task automatic check_zero_outputs();
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_code_err", code_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_word_len", word_len, 0);
    chk("rst_fsm_state", dbg_state, 0);
  endtask

  task automatic async_reset(input int n);
    @(posedge clk); #2;
    model_edge();
    #1;
    rst_n = 1'b0; code_valid = 1'b0; sync = 1'b0; data_ready = 1'b0;
    model_reset();
    #1;
    check_zero_outputs();
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int k;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_zero_outputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3, 1);

    // basic: 0100 1000 -> 1,0,1,1
    do_sync(1'b0, 1);
    send_cb(8'b01001000, 8, 1);
    idle(4, 1);

    // 6- and 8-bit words
    do_sync(1'b0, 1);
    send_cb(8'b000100, 6, 1);
    send_cb(8'b00100100, 8, 1);
    idle(6, 1);

    // unmatched word then a valid 1000
    do_sync(1'b0, 1);
    send_cb(8'b00000000, 8, 1);
    send_cb(8'b1000, 4, 1);
    idle(4, 1);

    // overflow: five "11" words with nobody reading, then sync clears the flag
    for (int i = 0; i < 5; i++) send_cb(8'b1000, 4, 0);
    idle(2, 0);
    do_sync(cur_lvl, 0);
    idle(3, 0);
    idle(12, 1);

    // toggling ready during decode
    do_sync(1'b1, 2);
    for (int i = 0; i < 20; i++) begin
      k = int'($urandom_range(0, 6));
      send_cb(tbl_code[k], tbl_clen[k], 2);
    end
    idle(20, 1);

    // reset mid-word, then bits without sync must be ignored
    do_sync(1'b0, 1);
    send_cb(8'b000, 3, 1);
    async_reset(2);
    send_cb(8'b10110100, 8, 1);
    send_cb(8'b1000, 4, 1);
    idle(3, 1);

    // randomized stream: words, garbage, resyncs, gaps, varying back-pressure
    do_sync(1'b0, 1);
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) rdy_pct = int'($urandom_range(10, 100));
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        do_sync(logic'($urandom_range(0, 1)), 3);
      end else if (r < 9) begin
        send_cb(8'($urandom_range(0, 255)), int'($urandom_range(1, 8)), 3);
      end else begin
        k = int'($urandom_range(0, 6));
        send_cb(tbl_code[k], tbl_clen[k], 3);
      end
    end

    idle(3 * FIFO_DEPTH, 1);
    @(negedge clk); #1;
    chk("fifo_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rll27_decoder.md
Name: rll27_decoder

Overview:
- Downstream stage of the RLL(2,7) line coder: consumes the NRZI-style line level it drives (one channel bit per `code_valid`) and recovers the original serial data.
- Pipeline: NRZI-to-transition conversion, then a prefix-free codeword parser, then a small bit FIFO that serializes recovered bits to the consumer with a valid/ready handshake.
- Flags malformed codewords and FIFO overflow for link diagnostics.

Parameters:
- FIFO_DEPTH, 8, capacity of the output bit FIFO in bits (power of 2, at least 4).
- ERR_CNT_W, 8, width of the saturating code-error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_in  in  1  line level from the coder (voltage level, NRZI).
- code_valid  in  1  qualifies `code_in`; one channel bit per asserted cycle.
- sync  in  1  frame start; single-cycle pulse aligned with the first line sample of a frame.
- data_out  out  1  recovered data bit (FIFO head).
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer accepts `data_out` when `data_valid` and `data_ready` are both high.
- code_err  out  1  one-cycle pulse on an unmatched 8-bit codeword.
- overflow  out  1  sticky: a decoded word was dropped for lack of FIFO space.
- err_cnt  out  ERR_CNT_W  saturating count of `code_err` pulses.
- word_len  out  3  length in data bits (2/3/4) of the last decoded word; 0 after reset or sync.

Behaviour:
- Reset (rst_n low, async): every output is 0; FIFO empty; parser count 0; reference level `prev_lvl` = 0; FSM = HUNT. Reset mid-word discards the partial word and all FIFO contents.
- FSM HUNT:
  - `code_valid` is ignored while no `sync` is present.
  - `sync` moves to RUN and loads `prev_lvl` with `code_in` that cycle; that sample produces no channel bit.
- FSM RUN: on each `code_valid` (without `sync`):
  - Channel bit `cb = code_in ^ prev_lvl`; then `prev_lvl <= code_in`.
  - Append `cb` to a parser shift register `pbuf` (newest bit in LSB); count `pcnt` increments.
- Match is evaluated on the appended value when `pcnt` becomes 4, 6 or 8. Code -> data table (MSB-first, first channel bit leftmost):
  - 4 bits: 0100 -> 10; 1000 -> 11.
  - 6 bits: 000100 -> 000; 100100 -> 010; 001000 -> 011.
  - 8 bits: 00100100 -> 0010; 00001000 -> 0011.
- The code table is prefix-free, so the first match is final.
- On a match:
  - Data bits are pushed into the FIFO in the same cycle, first data bit first.
  - `pcnt <= 0`; `word_len` updated.
- When `pcnt` reaches 8 with no match:
  - `code_err` pulses for 1 cycle and `err_cnt` increments, saturating at all-ones.
  - `pcnt <= 0`; no data is pushed; FSM stays in RUN.
- `sync` while in RUN:
  - Clears `pcnt`, `word_len` and `overflow`, and reloads `prev_lvl` from `code_in`.
  - FIFO contents are kept (data already recovered is not discarded).
- Latency: `data_valid` rises the cycle after the `code_valid` that completes the word, provided the FIFO was empty.
- FIFO:
  - Up to 4 pushes and 1 pop in a single cycle; simultaneous push and pop is allowed.
  - Free space is evaluated before that cycle's pop.
  - If free space is less than the word length, the whole word is dropped (never partially written) and `overflow` is set; it stays set until the next sync or reset.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
  - `data_out` is 0 when the FIFO is empty. A pop on an empty FIFO is ignored.
- `code_valid` low: parser and `prev_lvl` hold; FIFO may still drain.

Test Plan:
- Basic: reset, then sync with `code_in`=0, then levels 0,1,1,1,0,0,0,0 with `data_ready`=1 -> data bits 1,0,1,1; `word_len` 2 then 2; `code_err` never asserts.
- 6/8-bit words: code 000100 then 00100100 (NRZI from level 0) -> data 0,0,0,0,0,1,0; `word_len` 3 then 4.
- Error and resync: 8 constant levels after sync -> `code_err` pulses once after the 8th bit and `err_cnt`=1. A following valid 1000 decodes to 1,1.
- Overflow: `data_ready`=0, FIFO_DEPTH=8, five consecutive "11" words -> FIFO holds 8 ones; fifth word dropped and `overflow`=1. A sync clears `overflow` while the FIFO still holds 8 bits.
- Handshake: toggle `data_ready` every cycle during decode -> no bit lost or duplicated; output order matches the input data order.
- Reset mid-word: assert rst_n low after 3 bits of a 6-bit word -> all outputs 0 immediately; after release, bits are ignored until sync (HUNT).
